// File: rtl/sprite_pkg.sv
// Shared types and helpers for the sprite movement engine.
// Facing encoding matches the sprite ROM frame order.
package sprite_pkg;

    typedef enum logic [1:0] {
        DIR_DOWN  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_UP    = 2'd2,
        DIR_RIGHT = 2'd3
    } dir_t;

    // Signed step with saturation to [0, maxv]; int gives headroom for underflow.
    function automatic int sat_step(
        input int   pos,
        input logic inc,
        input logic dec,
        input int   step,
        input int   maxv
    );
        int v;
        v = pos;
        if (inc && !dec)
            v = pos + step;
        else if (dec && !inc)
            v = pos - step;
        if (v < 0)
            v = 0;
        else if (v > maxv)
            v = maxv;
        return v;
    endfunction

endpackage

// File: rtl/sprite_anim.sv
// Frame-clock synchroniser, move-tick divider and walk-cycle step counter.
// The tick is a single Clk pulse on every FRAME_DIV-th frame edge.
module sprite_anim #(
    parameter int FRAME_DIV   = 4,
    parameter int WALK_FRAMES = 3,
    parameter int SW          = 1
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic          i_frame_clk,
    input  logic          i_moving_next,
    output logic          o_tick,
    output logic [SW-1:0] o_step
);

    localparam int DW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;

    logic [2:0]    r_sync;
    logic [DW-1:0] r_div;
    logic [SW-1:0] r_step;
    logic          w_edge;
    logic          w_tick;

    assign w_edge = r_sync[1] & ~r_sync[2];
    assign w_tick = w_edge && (r_div == DW'(FRAME_DIV - 1));

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync <= '0;
            r_div  <= '0;
            r_step <= '0;
        end else begin
            r_sync <= {r_sync[1:0], i_frame_clk};
            if (w_edge)
                r_div <= w_tick ? '0 : r_div + DW'(1);
            if (w_tick) begin
                if (!i_moving_next)
                    r_step <= '0;
                else if (r_step == SW'(WALK_FRAMES - 2))
                    r_step <= '0;
                else
                    r_step <= r_step + SW'(1);
            end
        end
    end

    assign o_tick = w_tick;
    assign o_step = r_step;

endmodule

// File: rtl/sprite_mover.sv
// Sprite position, facing and walk-animation engine with a registered
// sprite-ROM address for the pixel currently being drawn.
module sprite_mover
    import sprite_pkg::*;
#(
    parameter int X_W         = 9,
    parameter int Y_W         = 9,
    parameter int SCREEN_W    = 320,
    parameter int SCREEN_H    = 240,
    parameter int WIDTH       = 18,
    parameter int HEIGHT      = 20,
    parameter int STEP        = 3,
    parameter int FRAME_DIV   = 4,
    parameter int WALK_FRAMES = 3,
    parameter int START_X     = 151,
    parameter int START_Y     = 110,
    parameter int ADDR_W      = 13
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic              frame_clk,
    input  logic              req_up,
    input  logic              req_down,
    input  logic              req_left,
    input  logic              req_right,
    input  logic              blocked,
    input  logic [X_W-1:0]    PixelX,
    input  logic [Y_W-1:0]    PixelY,
    output logic              is_obj,
    output logic [ADDR_W-1:0] Obj_address,
    output logic [X_W-1:0]    Obj_X_Pos,
    output logic [Y_W-1:0]    Obj_Y_Pos,
    output logic [1:0]        Obj_Direction,
    output logic              moving
);

    localparam int AW1  = ADDR_W + 1;
    localparam int XMAX = SCREEN_W - WIDTH;
    localparam int YMAX = SCREEN_H - HEIGHT;
    localparam int SW   = (WALK_FRAMES > 2) ? $clog2(WALK_FRAMES - 1) : 1;

    logic [X_W-1:0]    r_x;
    logic [Y_W-1:0]    r_y;
    dir_t              r_dir;
    logic              r_moving;
    logic              r_is_obj;
    logic [ADDR_W-1:0] r_addr;

    logic              w_xp, w_xn, w_yp, w_yn;
    logic              w_moving_next;
    logic              w_tick;
    logic [SW-1:0]     w_step;
    dir_t              w_dir_next;
    logic [X_W-1:0]    w_nx;
    logic [Y_W-1:0]    w_ny;
    logic              w_inside;
    logic [AW1-1:0]    w_frame;
    logic [AW1-1:0]    w_addr;

    assign w_xp = req_right & ~req_left;
    assign w_xn = req_left & ~req_right;
    assign w_yp = req_down & ~req_up;
    assign w_yn = req_up & ~req_down;

    assign w_moving_next = (w_xp | w_xn | w_yp | w_yn) & ~blocked;

    // Horizontal request wins the facing on diagonals
    always_comb begin
        w_dir_next = r_dir;
        if (w_xp)
            w_dir_next = DIR_RIGHT;
        else if (w_xn)
            w_dir_next = DIR_LEFT;
        else if (w_yp)
            w_dir_next = DIR_DOWN;
        else if (w_yn)
            w_dir_next = DIR_UP;
    end

    assign w_nx = X_W'(sat_step(int'(r_x), w_xp, w_xn, STEP, XMAX));
    assign w_ny = Y_W'(sat_step(int'(r_y), w_yp, w_yn, STEP, YMAX));

    sprite_anim #(
        .FRAME_DIV   (FRAME_DIV),
        .WALK_FRAMES (WALK_FRAMES),
        .SW          (SW)
    ) u_anim (
        .i_clk         (Clk),
        .i_rst_n       (Reset_n),
        .i_frame_clk   (frame_clk),
        .i_moving_next (w_moving_next),
        .o_tick        (w_tick),
        .o_step        (w_step)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_x      <= X_W'(START_X);
            r_y      <= Y_W'(START_Y);
            r_dir    <= DIR_DOWN;
            r_moving <= 1'b0;
        end else if (w_tick) begin
            r_dir    <= w_dir_next;
            r_moving <= w_moving_next;
            if (w_moving_next) begin
                r_x <= w_nx;
                r_y <= w_ny;
            end
        end
    end

    assign w_inside =
        ({1'b0, PixelX} >= {1'b0, r_x}) &&
        ({1'b0, PixelX} < ({1'b0, r_x} + (X_W+1)'(WIDTH))) &&
        ({1'b0, PixelY} >= {1'b0, r_y}) &&
        ({1'b0, PixelY} < ({1'b0, r_y} + (Y_W+1)'(HEIGHT)));

    assign w_frame = AW1'(r_dir) * AW1'(WALK_FRAMES)
                   + (r_moving ? AW1'(w_step) + AW1'(1) : AW1'(0));

    assign w_addr = AW1'(PixelY - r_y) * AW1'(WIDTH)
                  + AW1'(PixelX - r_x)
                  + w_frame * AW1'(WIDTH * HEIGHT);

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_is_obj <= 1'b0;
            r_addr   <= '0;
        end else begin
            r_is_obj <= w_inside;
            r_addr   <= w_inside ? ADDR_W'(w_addr) : '0;
        end
    end

    assign is_obj        = r_is_obj;
    assign Obj_address   = r_addr;
    assign Obj_X_Pos     = r_x;
    assign Obj_Y_Pos     = r_y;
    assign Obj_Direction = r_dir;
    assign moving        = r_moving;

endmodule

// File: tb/tb_sprite_mover.sv
// Directed bench for sprite_mover: movement, clamping, facing,
// walk-cycle frames and ROM address generation with default parameters.
module tb_sprite_mover;

    logic        Clk = 1'b0;
    logic        Reset_n = 1'b0;
    logic        frame_clk = 1'b0;
    logic        req_up = 1'b0, req_down = 1'b0;
    logic        req_left = 1'b0, req_right = 1'b0;
    logic        blocked = 1'b0;
    logic [8:0]  PixelX = '0;
    logic [8:0]  PixelY = '0;
    logic        is_obj;
    logic [12:0] Obj_address;
    logic [8:0]  Obj_X_Pos;
    logic [8:0]  Obj_Y_Pos;
    logic [1:0]  Obj_Direction;
    logic        moving;

    int n_assert = 0;
    int n_fail   = 0;

    sprite_mover dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .frame_clk     (frame_clk),
        .req_up        (req_up),
        .req_down      (req_down),
        .req_left      (req_left),
        .req_right     (req_right),
        .blocked       (blocked),
        .PixelX        (PixelX),
        .PixelY        (PixelY),
        .is_obj        (is_obj),
        .Obj_address   (Obj_address),
        .Obj_X_Pos     (Obj_X_Pos),
        .Obj_Y_Pos     (Obj_Y_Pos),
        .Obj_Direction (Obj_Direction),
        .moving        (moving)
    );

    always #10 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic frame_edge();
        @(negedge Clk) frame_clk = 1'b1;
        repeat (4) @(negedge Clk);
        frame_clk = 1'b0;
        repeat (4) @(negedge Clk);
    endtask

    task automatic tick(input int n);
        for (int i = 0; i < n; i++)
            repeat (4) frame_edge();
    endtask

    task automatic req(input logic u, input logic d,
                       input logic l, input logic r, input logic b);
        @(negedge Clk);
        req_up = u; req_down = d; req_left = l; req_right = r;
        blocked = b;
    endtask

    task automatic pix(input int x, input int y);
        @(negedge Clk);
        PixelX = 9'(x);
        PixelY = 9'(y);
        @(posedge Clk);
        #1;
    endtask

    initial begin
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        #1;
        chk("rst_x", Obj_X_Pos, 151);
        chk("rst_y", Obj_Y_Pos, 110);
        chk("rst_dir", Obj_Direction, 0);
        chk("rst_isobj", is_obj, 0);
        chk("rst_addr", Obj_address, 0);
        chk("rst_moving", moving, 0);

        req(0, 0, 0, 1, 0);
        repeat (3) frame_edge();
        chk("div3_x", Obj_X_Pos, 151);
        frame_edge();
        chk("tick1_x", Obj_X_Pos, 154);
        chk("tick1_dir", Obj_Direction, 3);
        chk("tick1_mov", moving, 1);
        tick(1);
        chk("tick2_x", Obj_X_Pos, 157);
        chk("tick2_y", Obj_Y_Pos, 110);

        req(1, 0, 1, 0, 0);
        tick(19);
        chk("diag_x", Obj_X_Pos, 100);
        chk("diag_y", Obj_Y_Pos, 53);
        chk("diag_dir", Obj_Direction, 1);
        req(1, 0, 0, 0, 0);
        tick(1);
        chk("up_y", Obj_Y_Pos, 50);
        chk("up_dir", Obj_Direction, 2);
        req(0, 0, 0, 0, 0);
        tick(1);
        chk("idle_mov", moving, 0);
        chk("idle_dir", Obj_Direction, 2);

        pix(105, 53);
        chk("in_isobj", is_obj, 1);
        chk("in_addr", Obj_address, 2219);
        pix(118, 53);
        chk("xedge_isobj", is_obj, 0);
        chk("xedge_addr", Obj_address, 0);
        pix(117, 69);
        chk("corner_addr", Obj_address, 19 * 18 + 17 + 6 * 360);
        pix(100, 70);
        chk("yedge_isobj", is_obj, 0);

        req(0, 1, 0, 0, 1);
        tick(1);
        chk("blk_y", Obj_Y_Pos, 50);
        chk("blk_dir", Obj_Direction, 0);
        chk("blk_mov", moving, 0);

        req(0, 1, 0, 0, 0);
        tick(1);
        chk("walk1_y", Obj_Y_Pos, 53);
        pix(100, 72);
        chk("walk1_addr", Obj_address, 1062);
        tick(1);
        chk("walk2_y", Obj_Y_Pos, 56);
        pix(100, 75);
        chk("walk2_addr", Obj_address, 702);

        req(1, 0, 1, 0, 0);
        tick(18);
        req(0, 0, 1, 0, 0);
        tick(15);
        chk("pre_x", Obj_X_Pos, 1);
        chk("pre_y", Obj_Y_Pos, 2);
        req(1, 0, 1, 0, 0);
        tick(1);
        chk("clamp_x", Obj_X_Pos, 0);
        chk("clamp_y", Obj_Y_Pos, 0);
        chk("clamp_dir", Obj_Direction, 1);
        chk("clamp_mov", moving, 1);
        tick(1);
        chk("stuck_x", Obj_X_Pos, 0);
        chk("stuck_y", Obj_Y_Pos, 0);
        chk("stuck_mov", moving, 1);
        req(0, 0, 1, 1, 0);
        tick(1);
        chk("cancel_mov", moving, 0);
        chk("cancel_dir", Obj_Direction, 1);
        chk("cancel_x", Obj_X_Pos, 0);

        pix(0, 0);
        chk("pre_rst_isobj", is_obj, 1);
        @(negedge Clk);
        #3 Reset_n = 1'b0;
        #1;
        chk("async_x", Obj_X_Pos, 151);
        chk("async_y", Obj_Y_Pos, 110);
        chk("async_dir", Obj_Direction, 0);
        chk("async_mov", moving, 0);
        chk("async_isobj", is_obj, 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_mover.md
Name: sprite_mover

Overview:
Parametrised position, direction and walk-animation engine for any on-screen sprite (player, zombies) in the 320x240 game field.
- Takes decoded direction requests and a collision-block input.
- Supports diagonal movement, clamps exactly at screen edges and advances a configurable walk cycle.
- Outputs a registered sprite-ROM address for the pixel currently being drawn.
- Sits between the keycode/AI decoder and the sprite ROM / colour mapper.

Parameters:
- X_W, 9, pixel X coordinate width
- Y_W, 9, pixel Y coordinate width
- SCREEN_W, 320, field width in pixels
- SCREEN_H, 240, field height in pixels
- WIDTH, 18, sprite width
- HEIGHT, 20, sprite height
- STEP, 3, pixels moved per axis per move tick
- FRAME_DIV, 4, frame edges per move tick (>=1)
- WALK_FRAMES, 3, ROM frames per direction: 1 idle + (WALK_FRAMES-1) walking (>=2)
- START_X, 151, reset X (upper-left corner)
- START_Y, 110, reset Y (upper-left corner)
- ADDR_W, 13, sprite ROM address width; must cover 4*WALK_FRAMES*WIDTH*HEIGHT

Ports:
- Clk  in  1  50 MHz system clock
- Reset_n  in  1  asynchronous, active-low reset
- frame_clk  in  1  vertical-sync-rate frame clock (~60 Hz)
- req_up, req_down, req_left, req_right  in  1 each  movement requests, level-sensitive
- blocked  in  1  collision veto, sampled only on a move tick
- PixelX  in  X_W  current draw X
- PixelY  in  Y_W  current draw Y
- is_obj  out  1  registered: pixel lies inside the sprite box
- Obj_address  out  ADDR_W  registered sprite-ROM address
- Obj_X_Pos  out  X_W  upper-left X
- Obj_Y_Pos  out  Y_W  upper-left Y
- Obj_Direction  out  2  facing: 0 down, 1 left, 2 up, 3 right
- moving  out  1  a move occurred on the last tick

Behaviour:
Reset
- Reset_n low asynchronously sets: Obj_X_Pos=START_X, Obj_Y_Pos=START_Y, Obj_Direction=0, moving=0, is_obj=0, Obj_address=0; all counters and the edge detector to 0.
- Reset asserted mid-tick discards that tick.

Frame edge and move tick
- frame_clk goes through a 2-flop synchroniser, then rising-edge detect, giving a 1-Clk pulse.
- Divider counts edges 0..FRAME_DIV-1. The move tick is a 1-Clk pulse on the edge where the count equals FRAME_DIV-1; the counter then wraps to 0.
- FRAME_DIV=1 means every edge is a tick.

On a tick
- Axis requests: dx = right-left and dy = down-up, each in {-1,0,+1}. Opposing requests cancel.
- Direction update: if dx!=0, Obj_Direction = left/right; else if dy!=0, up/down; else unchanged. Horizontal wins on diagonals.
- Direction updates even when blocked=1.
- If blocked=1 or dx=dy=0: position unchanged, moving=0.
- Otherwise each axis moves STEP in its sign, with saturating clamp:
  - X range [0, SCREEN_W-WIDTH], Y range [0, SCREEN_H-HEIGHT].
  - Example: X=1, left → X=0, not wrap.
  - Compute with one extra bit to detect underflow.
- moving=1 iff the requested direction was non-zero and not blocked, even if the clamp made the net motion zero.
- Between ticks all state holds.

Walk animation
- Step counter runs 0..WALK_FRAMES-2 and wraps.
- Increments on each tick with moving=1; clears to 0 on any tick with moving=0.
- frame = Obj_Direction*WALK_FRAMES + (moving ? 1+step : 0).

Address generation, 1-Clk latency
- Inside test: PixelX>=X && PixelX<X+WIDTH && PixelY>=Y && PixelY<Y+HEIGHT.
- Inside: next Obj_address = (PixelY-Y)*WIDTH + (PixelX-X) + frame*WIDTH*HEIGHT, and is_obj=1.
- Outside: Obj_address=0, is_obj=0.
- Both registered. Multiplications by constants only; intermediate width is ADDR_W+1, truncated to ADDR_W.

Decomposition:
- sprite_pkg:
  - dir_t enum: DIR_DOWN=0, DIR_LEFT=1, DIR_UP=2, DIR_RIGHT=3
  - sat_step function: signed step with clamp
- Sub-module sprite_anim:
  - frame synchroniser, edge detect and FRAME_DIV divider
  - step counter
  - outputs: tick, step
  - inputs: moving_next

Test Plan:
- Reset with defaults → Obj_X_Pos=151, Obj_Y_Pos=110, Obj_Direction=0, is_obj=0, Obj_address=0. Assert Reset_n low between Clk edges → outputs change immediately.
- Hold req_right for 4 frame edges (FRAME_DIV=4) → exactly one tick, X=154, Direction=3, moving=1. After 4 more edges → X=157, step wraps 0→1→0 (WALK_FRAMES=3).
- req_up+req_left at X=1, Y=2 → X=0, Y=0, Direction=1, moving=1. Next tick → position unchanged, moving=1. req_left+req_right alone → no motion, moving=0.
- blocked=1 with req_down → position unchanged, Direction=0, moving=0, step cleared.
- Idle, Direction=2, X=100, Y=50; PixelX=105, PixelY=53 → one Clk later is_obj=1, Obj_address=3*18+5+6*360=2219. PixelX=118 → is_obj=0, Obj_address=0.
- Walking down on step 1 (frame 2), PixelX=X, PixelY=Y+19 → Obj_address=342+720=1062.
